// File: rtl/gps_source_arbiter.sv
// Round-robin arbiter that lends one GPZDA sentence parser to N byte sources,
// one whole sentence ($ .. LF) at a time, counting every byte it has to discard.
module gps_source_arbiter #(
  parameter int             N             = 2,
  parameter int             B             = 8,
  parameter logic [B-1:0]   Start         = B'(8'h24),
  parameter logic [B-1:0]   End           = B'(8'h0A),
  parameter int             TimeoutCycles = 100000,
  parameter int             CountWidth    = 16,
  localparam int            IdW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N-1:0]          src_load,
  input  logic [N*B-1:0]        src_data,
  output logic                  rx_load,
  output logic [B-1:0]          rx_data,
  output logic                  parser_reset,
  output logic                  grant_valid,
  output logic [IdW-1:0]        grant_id,
  output logic                  timeout,
  output logic                  abort,
  output logic [CountWidth-1:0] dropped_count
);

  localparam int TcW  = $clog2(TimeoutCycles + 1);
  localparam int SumW = CountWidth + 4;
  localparam logic [SumW-1:0] CntMax = SumW'({CountWidth{1'b1}});

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_FLUSH} state_t;

  state_t           r_state;
  logic [IdW-1:0]   r_ptr;
  logic [TcW-1:0]   r_idle_cnt;

  logic [N-1:0]          w_cand;
  logic                  w_found;
  logic [IdW-1:0]        w_winner;
  logic                  w_gnt_load;
  logic [B-1:0]          w_gnt_byte;
  int                    w_idx;
  int                    w_drop;
  logic [SumW-1:0]       w_sum;
  logic [CountWidth-1:0] w_cnt_next;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_cand     = '0;
    w_found    = 1'b0;
    w_winner   = '0;
    w_idx      = 0;
    w_drop     = 0;
    for (int i = 0; i < N; i++)
      w_cand[i] = src_load[i] && (src_data[i*B +: B] == Start);

    // First candidate at or after the pointer, wrapping modulo N.
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IdW'(w_idx);
      end
    end

    w_gnt_load = src_load[grant_id];
    w_gnt_byte = src_data[int'(grant_id)*B +: B];

    case (r_state)
      ST_IDLE:  w_drop = w_found ? $countones(w_cand) - 1 : 0;
      ST_LOCK:  w_drop = $countones(src_load) - int'(w_gnt_load);
      ST_FLUSH: w_drop = $countones(src_load);
      default:  w_drop = 0;
    endcase

    w_sum      = SumW'(dropped_count) + SumW'(w_drop);
    w_cnt_next = (w_sum > CntMax) ? '1 : w_sum[CountWidth-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_idle_cnt    <= '0;
      rx_load       <= 1'b0;
      rx_data       <= '0;
      parser_reset  <= 1'b0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      timeout       <= 1'b0;
      abort         <= 1'b0;
      dropped_count <= '0;
    end else begin
      rx_load       <= 1'b0;
      parser_reset  <= 1'b0;
      timeout       <= 1'b0;
      abort         <= 1'b0;
      dropped_count <= w_cnt_next;

      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            rx_load     <= 1'b1;
            rx_data     <= Start;
            grant_valid <= 1'b1;
            grant_id    <= w_winner;
            r_idle_cnt  <= '0;
            r_state     <= ST_LOCK;
          end
        end

        ST_LOCK: begin
          if (w_gnt_load) begin
            if (w_gnt_byte == Start) begin
              abort   <= 1'b1;
              r_state <= ST_FLUSH;
            end else begin
              rx_load    <= 1'b1;
              rx_data    <= w_gnt_byte;
              r_idle_cnt <= '0;
              if (w_gnt_byte == End) r_state <= ST_FLUSH;
            end
          end else if (r_idle_cnt == TcW'(TimeoutCycles - 1)) begin
            timeout <= 1'b1;
            r_state <= ST_FLUSH;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end

        ST_FLUSH: begin
          // Reset lands one cycle after the last forwarded byte.
          parser_reset <= 1'b1;
          grant_valid  <= 1'b0;
          r_ptr        <= (grant_id == IdW'(N - 1)) ? '0 : grant_id + 1'b1;
          r_state      <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_source_arbiter.sv
// Directed bench for gps_source_arbiter (N=2, TimeoutCycles=20): one tick per
// clock, outputs sampled 1 ns after the rising edge that consumed the inputs.
module tb_gps_source_arbiter;

  localparam int N  = 2;
  localparam int B  = 8;
  localparam int TO = 20;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  src_load = '0;
  logic [N*B-1:0] src_data = '0;
  logic          rx_load;
  logic [B-1:0]  rx_data;
  logic          parser_reset;
  logic          grant_valid;
  logic [0:0]    grant_id;
  logic          timeout;
  logic          abort;
  logic [15:0]   dropped_count;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_count = 0;
  int pr_count = 0;
  int to_count = 0;

  gps_source_arbiter #(
    .N(N), .B(B), .Start(8'h24), .End(8'h0A),
    .TimeoutCycles(TO), .CountWidth(16)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .src_load(src_load), .src_data(src_data),
    .rx_load(rx_load), .rx_data(rx_data), .parser_reset(parser_reset),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .timeout(timeout), .abort(abort), .dropped_count(dropped_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given inputs; outputs then show the response.
  task automatic tick(input logic [N-1:0] ld, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clock);
    src_load = ld;
    src_data = {d1, d0};
    @(posedge clock);
    #1;
    if (rx_load)      rx_count++;
    if (parser_reset) pr_count++;
    if (timeout)      to_count++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    src_load = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    string a;
    string b;

    do_reset();
    check("rst_rx_load", rx_load, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_dropped", dropped_count, 0);

    // Test 1: full 38-byte sentence from source 0, 9 idle clocks between bytes.
    s = {"$GPZDA,201530.00,04,07,2002,00,00*60", "\015", "\n"};
    rx_count = 0; pr_count = 0;
    for (int i = 0; i < s.len(); i++) begin
      tick(2'b01, s[i], 8'h00);
      check("t1_rx_load", rx_load, 1);
      check("t1_rx_data", rx_data, s[i]);
      if (i < s.len() - 1) repeat (9) tick(2'b00, 8'h00, 8'h00);
    end
    check("t1_gv_last", grant_valid, 1);
    check("t1_pr_early", pr_count, 0);
    tick(2'b00, 8'h00, 8'h00);
    check("t1_parser_reset", parser_reset, 1);
    check("t1_gv_clear", grant_valid, 0);
    check("t1_grant_id", grant_id, 0);
    repeat (3) tick(2'b00, 8'h00, 8'h00);
    check("t1_rx_count", rx_count, 38);
    check("t1_pr_count", pr_count, 1);
    check("t1_dropped", dropped_count, 0);

    // Test 2: simultaneous '$' with pointer 0, then pointer 1.
    do_reset();
    tick(2'b11, "$", "$");
    check("t2_gid0", grant_id, 0);
    check("t2_gv", grant_valid, 1);
    check("t2_rx", rx_data, "$");
    check("t2_drop1", dropped_count, 1);
    tick(2'b01, "G", 8'h00);
    tick(2'b01, "P", 8'h00);
    tick(2'b11, "\n", "$");
    check("t2_end_fwd", rx_data, 8'h0A);
    check("t2_end_load", rx_load, 1);
    check("t2_drop2", dropped_count, 2);
    tick(2'b10, 8'h00, "z");
    check("t2_flush_pr", parser_reset, 1);
    check("t2_flush_drop", dropped_count, 3);
    tick(2'b11, "$", "$");
    check("t2_gid1", grant_id, 1);
    check("t2_rx_load", rx_load, 1);
    check("t2_drop4", dropped_count, 4);
    tick(2'b10, 8'h00, "\n");
    check("t2_src1_end", rx_data, 8'h0A);
    tick(2'b00, 8'h00, 8'h00);

    // Test 3: source 1 chatter while source 0 owns the grant.
    do_reset();
    tick(2'b01, "$", 8'h00);
    check("t3_gid", grant_id, 0);
    a = "GPZDA";
    b = "$bc$e";
    for (int i = 0; i < 5; i++) begin
      tick(2'b11, a[i], b[i]);
      check("t3_rx_load", rx_load, 1);
      check("t3_rx_data", rx_data, a[i]);
    end
    check("t3_dropped", dropped_count, 5);
    check("t3_no_abort", abort, 0);
    tick(2'b01, "\n", 8'h00);
    check("t3_end", rx_data, 8'h0A);
    tick(2'b00, 8'h00, 8'h00);

    // Test 4: timeout 20 cycles after the last byte.
    tick(2'b01, "$", 8'h00);
    check("t4_gid", grant_id, 0);
    tick(2'b01, "G", 8'h00);
    tick(2'b01, "P", 8'h00);
    to_count = 0;
    repeat (TO - 1) tick(2'b00, 8'h00, 8'h00);
    check("t4_no_early_to", to_count, 0);
    check("t4_gv_hold", grant_valid, 1);
    tick(2'b00, 8'h00, 8'h00);
    check("t4_timeout", timeout, 1);
    check("t4_rx_idle", rx_load, 0);
    tick(2'b00, 8'h00, 8'h00);
    check("t4_pr", parser_reset, 1);
    check("t4_to_pulse", timeout, 0);
    check("t4_gv", grant_valid, 0);
    check("t4_dropped", dropped_count, 5);

    // Test 5: mid-sentence '$' aborts, then a fresh '$' is granted.
    tick(2'b01, "$", 8'h00);
    check("t5_gv", grant_valid, 1);
    tick(2'b01, "G", 8'h00);
    tick(2'b01, "P", 8'h00);
    tick(2'b01, "Z", 8'h00);
    tick(2'b01, "$", 8'h00);
    check("t5_abort", abort, 1);
    check("t5_no_fwd", rx_load, 0);
    tick(2'b00, 8'h00, 8'h00);
    check("t5_pr", parser_reset, 1);
    check("t5_abort_pulse", abort, 0);
    check("t5_gv_clear", grant_valid, 0);
    tick(2'b10, 8'h00, "$");
    check("t5_regrant_load", rx_load, 1);
    check("t5_regrant_id", grant_id, 1);
    check("t5_regrant_data", rx_data, "$");

    // Test 6: asynchronous reset mid-sentence.
    tick(2'b11, "x", "G");
    check("t6_fwd", rx_data, "G");
    check("t6_drop", dropped_count, 6);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_rx_load", rx_load, 0);
    check("t6_rst_rx_data", rx_data, 0);
    check("t6_rst_gv", grant_valid, 0);
    check("t6_rst_gid", grant_id, 0);
    check("t6_rst_drop", dropped_count, 0);
    check("t6_rst_pr", parser_reset, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    tick(2'b10, 8'h00, "$");
    check("t6_gid", grant_id, 1);
    check("t6_gv", grant_valid, 1);
    check("t6_rx", rx_data, "$");
    check("t6_drop_after", dropped_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
